// File: rtl/ita_fifo_drain.sv
// ita_fifo_drain
// Read side of the requantized-output FIFO. Pops FIFO_WIDTH-bit words from a
// first-word-fall-through FIFO into a single-entry holding register and
// serializes each word LSB-first as BEATS = FIFO_WIDTH/OUT_WIDTH beats on a
// valid/ready stream. A per-tile word counter flags the tile's final beat.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               synchronous clear of all state (beats accept/pop)
//   fifo_empty_i          FIFO empty flag
//   fifo_data_i           FIFO head word, valid while !fifo_empty_i
//   pop_from_fifo_o       consume the head word this cycle (combinational)
//   words_per_tile_i      words per tile, static while busy_o=1
//   valid_o/ready_i       output beat handshake
//   data_o                current beat
//   last_o                final beat of the tile
//   busy_o                holding register occupied or tile partially drained
//
// Optional feature (macro ITA_FIFO_DRAIN_PERF_EN):
//   stall_cycles_o        saturating count of valid_o & !ready_i cycles
//   starve_cycles_o       saturating count of mid-tile empty-FIFO cycles
module ita_fifo_drain #(
  parameter int unsigned FIFO_WIDTH = 128,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [FIFO_WIDTH-1:0] fifo_data_i,
  output logic                  pop_from_fifo_o,
  input  logic [CNT_WIDTH-1:0]  words_per_tile_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  last_o,
  output logic                  busy_o
`ifdef ITA_FIFO_DRAIN_PERF_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           starve_cycles_o
`endif
);

  localparam int unsigned BEATS  = FIFO_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Slice table is padded to a power of two so beat_q can index it directly.
  localparam int unsigned SLOTS  = 1 << BEAT_W;

  if (FIFO_WIDTH % OUT_WIDTH != 0) begin : g_width_check
    $fatal(1, "ita_fifo_drain: FIFO_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic [FIFO_WIDTH-1:0] word_q;
  logic                  full_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [CNT_WIDTH-1:0]  tile_cnt_q;

  logic                  accept;
  logic                  beat_is_last;
  logic                  lb;
  logic                  tile_last;
  logic                  pop;
  logic [OUT_WIDTH-1:0]  beat_slice [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slice
      if (gi < BEATS) begin : g_real
        assign beat_slice[gi] = word_q[gi*OUT_WIDTH +: OUT_WIDTH];
      end else begin : g_pad
        assign beat_slice[gi] = '0;
      end
    end
  endgenerate

  assign beat_is_last = (beat_q == BEAT_W'(BEATS - 1));
  assign accept       = full_q & ready_i;
  assign lb           = accept & beat_is_last;
  // A zero tile length never matches, so the counter just wraps.
  assign tile_last    = (words_per_tile_i != '0) &&
                        (tile_cnt_q == words_per_tile_i - CNT_WIDTH'(1));
  // Refill on the last beat keeps valid_o high across word boundaries.
  assign pop          = !fifo_empty_i & !flush_i & (!full_q | lb);

  assign pop_from_fifo_o = pop;
  assign valid_o         = full_q;
  assign data_o          = beat_slice[beat_q];
  assign last_o          = full_q & beat_is_last & tile_last;
  assign busy_o          = full_q | (tile_cnt_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q     <= '0;
      full_q     <= 1'b0;
      beat_q     <= '0;
      tile_cnt_q <= '0;
    end else if (flush_i) begin
      word_q     <= '0;
      full_q     <= 1'b0;
      beat_q     <= '0;
      tile_cnt_q <= '0;
    end else begin
      if (pop) begin
        word_q <= fifo_data_i;
        full_q <= 1'b1;
        beat_q <= '0;
      end else if (lb) begin
        full_q <= 1'b0;
      end else if (accept) begin
        beat_q <= beat_q + BEAT_W'(1);
      end

      if (lb) begin
        if (tile_last) begin
          tile_cnt_q <= '0;
        end else begin
          tile_cnt_q <= tile_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef ITA_FIFO_DRAIN_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] starve_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else if (flush_i) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (full_q && !ready_i && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      // Starved: mid-tile, nothing held and nothing to pop.
      if (!full_q && fifo_empty_i && (tile_cnt_q != '0) && (starve_q != '1)) begin
        starve_q <= starve_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o  = stall_q;
  assign starve_cycles_o = starve_q;
`endif

endmodule
